ball_velocity_estimator: RTL and testbench

// Converts per-frame ball X centroids from the vision front end into filtered

---
 rtl/ball_velocity_estimator.sv | 185 ++++++++++++++++++
 tb/tb_ball_velocity_estimator.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_velocity_estimator.sv
// Ball X tracker: a moving average with a jump gate produces filtered X and signed velocity.
// Latency: the strobe is sampled at edge 0 and o_X/o_VX/o_update are registered at edge 2.
// Backpressure: none. A strobe arriving while an earlier one is in flight is dropped and counted.
module ball_velocity_estimator #(
    parameter int          AVG_LOG2    = 2,
    parameter int          VEL_SHIFT   = 3,
    parameter logic [15:0] MAX_JUMP    = 16'd200,
    parameter logic [7:0]  LOST_FRAMES = 8'd8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_pos_valid,
    input  logic        i_found,
    input  logic [15:0] i_pos_x,
    output logic [15:0] o_X,
    output logic [15:0] o_VX,
    output logic        o_update,
    output logic        o_tracking,
    output logic        o_lost,
    output logic [31:0] o_debug
);
    localparam int N  = 1 << AVG_LOG2;
    localparam int SW = 16 + AVG_LOG2;
    localparam int VW = 17 + VEL_SHIFT;
    localparam logic signed [VW-1:0] SAT_HI = VW'(32767);
    localparam logic signed [VW-1:0] SAT_LO = -SAT_HI;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_TRACK = 2'd1,
        S_COAST = 2'd2,
        S_LOST  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_s1_vld, r_s1_found;
    logic [15:0]           r_s1_x;
    logic                  r_s2_vld, r_s2_seed, r_s2_acc, r_s2_lost;
    logic [15:0]           r_s2_x;
    logic [15:0]           r_buf [N];
    logic [SW-1:0]         r_sum;
    logic [AVG_LOG2-1:0]   r_wr;
    logic [15:0]           r_last_x, r_avg_prev;
    logic [7:0]            r_miss, r_drop;
    logic [15:0]           r_x, r_vx;
    logic                  r_update;

    logic                  w_busy, w_near, w_accept, w_seed, w_lost_now;
    logic                  w_idle_state;
    logic signed [16:0]    w_dx;
    logic [16:0]           w_adx;
    logic [7:0]            w_miss_inc;
    logic [15:0]           w_avg;
    logic signed [16:0]    w_diff;
    logic signed [VW-1:0]  w_vx_wide;
    logic [15:0]           w_vx_sat;

    assign w_busy       = r_s1_vld | r_s2_vld;
    assign w_idle_state = (r_state == S_EMPTY) || (r_state == S_LOST);
    assign w_dx         = $signed({1'b0, r_s1_x}) - $signed({1'b0, r_last_x});
    assign w_adx        = w_dx[16] ? 17'(-w_dx) : 17'(w_dx);
    assign w_near       = (w_adx <= {1'b0, MAX_JUMP});
    assign w_accept     = r_s1_found && (w_idle_state || w_near);
    assign w_seed       = w_accept && w_idle_state;
    assign w_miss_inc   = (r_miss == 8'hFF) ? r_miss : r_miss + 8'd1;

    // Stage 0: admit a strobe only when the pipeline is empty.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s1_vld   <= 1'b0;
            r_s1_found <= 1'b0;
            r_s1_x     <= '0;
            r_drop     <= '0;
        end else begin
            r_s1_vld <= i_pos_valid && !w_busy;
            if (i_pos_valid && !w_busy) begin
                r_s1_found <= i_found;
                r_s1_x     <= i_pos_x;
            end
            if (i_pos_valid && w_busy && (r_drop != 8'hFF))
                r_drop <= r_drop + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= S_EMPTY;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lost_now  = 1'b0;
        if (r_s1_vld) begin
            if (w_accept) begin
                w_state_nxt = S_TRACK;
            end else begin
                case (r_state)
                    S_TRACK: w_state_nxt = S_COAST;
                    S_COAST: begin
                        if (w_miss_inc >= LOST_FRAMES) begin
                            w_state_nxt = S_LOST;
                            w_lost_now  = 1'b1;
                        end
                    end
                    default: w_state_nxt = r_state;
                endcase
            end
        end
    end

    // Stage 1: gate decision, averaging buffer and running sum.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s2_vld  <= 1'b0;
            r_s2_seed <= 1'b0;
            r_s2_acc  <= 1'b0;
            r_s2_lost <= 1'b0;
            r_s2_x    <= '0;
            r_sum     <= '0;
            r_wr      <= '0;
            r_last_x  <= '0;
            r_miss    <= '0;
            for (int i = 0; i < N; i++) r_buf[i] <= '0;
        end else begin
            r_s2_vld  <= r_s1_vld;
            r_s2_seed <= r_s1_vld && w_seed;
            r_s2_acc  <= r_s1_vld && w_accept && !w_seed;
            r_s2_lost <= w_lost_now;
            r_s2_x    <= r_s1_x;
            if (r_s1_vld) begin
                if (w_accept) begin
                    r_last_x <= r_s1_x;
                    r_miss   <= '0;
                    if (w_seed) begin
                        for (int i = 0; i < N; i++) r_buf[i] <= r_s1_x;
                        r_sum <= {r_s1_x, {AVG_LOG2{1'b0}}};
                    end else begin
                        r_sum       <= r_sum - SW'(r_buf[r_wr]) + SW'(r_s1_x);
                        r_buf[r_wr] <= r_s1_x;
                        r_wr        <= r_wr + AVG_LOG2'(1);
                    end
                end else begin
                    r_miss <= w_miss_inc;
                end
            end
        end
    end

    assign w_avg     = r_sum[SW-1:AVG_LOG2];
    assign w_diff    = $signed({1'b0, w_avg}) - $signed({1'b0, r_avg_prev});
    assign w_vx_wide = VW'(w_diff) <<< VEL_SHIFT;
    assign w_vx_sat  = (w_vx_wide > SAT_HI) ? 16'h7FFF :
                       (w_vx_wide < SAT_LO) ? 16'h8001 : w_vx_wide[15:0];

    // Stage 2: average, velocity and the output registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_x        <= '0;
            r_vx       <= '0;
            r_update   <= 1'b0;
            r_avg_prev <= '0;
        end else begin
            r_update <= r_s2_vld;
            if (r_s2_seed) begin
                r_x        <= r_s2_x;
                r_vx       <= '0;
                r_avg_prev <= r_s2_x;
            end else if (r_s2_acc) begin
                r_x        <= w_avg;
                r_vx       <= w_vx_sat;
                r_avg_prev <= w_avg;
            end else if (r_s2_lost) begin
                r_vx <= '0;
            end
        end
    end

    assign o_X        = r_x;
    assign o_VX       = r_vx;
    assign o_update   = r_update;
    assign o_tracking = (r_state == S_TRACK) || (r_state == S_COAST);
    assign o_lost     = (r_state == S_LOST);
    assign o_debug    = {r_drop, r_miss, 14'd0, r_state};
endmodule

// File: tb/tb_ball_velocity_estimator.sv
// Bench for ball_velocity_estimator: directed scenarios plus random frames checked against a frame-level model.
module tb_ball_velocity_estimator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        pos_valid, found;
    logic [15:0] pos_x;
    logic [15:0] o_X, o_VX, o2_X, o2_VX;
    logic        o_update, o_tracking, o_lost, o2_update, o2_tracking, o2_lost;
    logic [31:0] o_debug, o2_debug;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    ball_velocity_estimator u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_pos_valid(pos_valid), .i_found(found),
        .i_pos_x(pos_x), .o_X(o_X), .o_VX(o_VX), .o_update(o_update),
        .o_tracking(o_tracking), .o_lost(o_lost), .o_debug(o_debug));

    ball_velocity_estimator #(.VEL_SHIFT(10)) u_dut_fast (
        .i_clk(clk), .i_reset_n(rst_n), .i_pos_valid(pos_valid), .i_found(found),
        .i_pos_x(pos_x), .o_X(o2_X), .o_VX(o2_VX), .o_update(o2_update),
        .o_tracking(o2_tracking), .o_lost(o2_lost), .o_debug(o2_debug));

    wire [66:0] obs = {o_update, o_tracking, o_lost, o_X, o_VX, o_debug};

    // Frame-level reference: history of the last four accepted positions.
    int m_state, m_miss, m_drop, m_X, m_VX, m_avg_prev, m_last;
    int hist[$];

    function automatic void model_reset();
        m_state = 0; m_miss = 0; m_drop = 0; m_X = 0; m_VX = 0;
        m_avg_prev = 0; m_last = 0;
        hist = {0, 0, 0, 0};
    endfunction

    function automatic void model_frame(bit f, int x);
        int d, sum, avg;
        d = (x > m_last) ? x - m_last : m_last - x;
        if (f && (m_state == 0 || m_state == 3)) begin
            hist = {x, x, x, x};
            m_X = x; m_VX = 0; m_avg_prev = x; m_last = x; m_miss = 0; m_state = 1;
        end else if (f && d <= 200) begin
            void'(hist.pop_front());
            hist.push_back(x);
            sum = hist[0] + hist[1] + hist[2] + hist[3];
            avg = sum / 4;
            m_VX = (avg - m_avg_prev) * 8;
            if (m_VX > 32767) m_VX = 32767;
            if (m_VX < -32767) m_VX = -32767;
            m_X = avg; m_avg_prev = avg; m_last = x; m_miss = 0; m_state = 1;
        end else begin
            if (m_miss < 255) m_miss++;
            if (m_state == 1) m_state = 2;
            else if (m_state == 2 && m_miss >= 8) begin
                m_state = 3; m_VX = 0;
            end
        end
    endfunction

    function automatic logic [66:0] exp_vec();
        logic trk, lst;
        trk = (m_state == 1 || m_state == 2);
        lst = (m_state == 3);
        return {1'b1, trk, lst, 16'(m_X), 16'(m_VX), 8'(m_drop), 8'(m_miss), 14'd0, 2'(m_state)};
    endfunction

    // Drives one strobe at the current falling edge; returns on the falling edge where o_update is high.
    task automatic strobe(input bit f, input logic [15:0] x);
        pos_valid = 1'b1; found = f; pos_x = x;
        @(negedge clk);
        pos_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic strobe_pair(input bit f, input logic [15:0] x, input logic [15:0] x2);
        pos_valid = 1'b1; found = f; pos_x = x;
        @(negedge clk);
        pos_x = x2;
        @(negedge clk);
        pos_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pos_valid = 1'b0; found = 1'b0; pos_x = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pos_valid = 1'b0; found = 1'b0; pos_x = '0;
        @(negedge clk);
        n_vec++;
        if (obs !== 67'd0) begin
            n_err++; $display("FAIL reset_hold obs=%h exp=%h", obs, 67'd0);
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        n_vec++;
        if (obs !== 67'd0) begin
            n_err++; $display("FAIL reset_release obs=%h exp=%h", obs, 67'd0);
        end
    endtask

    task automatic test_track();
        int ex[4] = '{602, 607, 615, 625};
        int ev[4] = '{16, 40, 64, 80};
        do_reset();
        strobe(1'b1, 16'd600);
        model_frame(1'b1, 600);
        n_vec++;
        if (obs !== exp_vec() || o_X !== 16'd600 || o_tracking !== 1'b1) begin
            n_err++; $display("FAIL seed obs=%h exp=%h", obs, exp_vec());
        end
        for (int i = 0; i < 4; i++) begin
            strobe(1'b1, 16'(610 + 10 * i));
            model_frame(1'b1, 610 + 10 * i);
            n_vec++;
            if (obs !== exp_vec() || o_X !== 16'(ex[i]) || o_VX !== 16'(ev[i])) begin
                n_err++; $display("FAIL track%0d obs=%h exp=%h x=%0d vx=%0d", i, obs, exp_vec(), ex[i], ev[i]);
            end
        end
    endtask

    task automatic test_gate();
        do_reset();
        strobe(1'b1, 16'd600);
        model_frame(1'b1, 600);
        strobe(1'b1, 16'd900);
        model_frame(1'b1, 900);
        n_vec++;
        if (obs !== exp_vec() || o_X !== 16'd600 || o_debug[1:0] !== 2'd2 || o_debug[23:16] !== 8'd1) begin
            n_err++; $display("FAIL gate_reject obs=%h exp=%h", obs, exp_vec());
        end
        strobe(1'b1, 16'd800);
        model_frame(1'b1, 800);
        n_vec++;
        if (obs !== exp_vec()) begin
            n_err++; $display("FAIL gate_edge obs=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_lost();
        do_reset();
        strobe(1'b1, 16'd500);
        model_frame(1'b1, 500);
        strobe(1'b1, 16'd560);
        model_frame(1'b1, 560);
        for (int i = 0; i < 8; i++) begin
            strobe(1'b0, 16'd0);
            model_frame(1'b0, 0);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL miss%0d obs=%h exp=%h", i, obs, exp_vec());
            end
        end
        n_vec++;
        if (o_lost !== 1'b1 || o_VX !== 16'd0) begin
            n_err++; $display("FAIL lost_flag lost=%b vx=%h exp lost=1 vx=0", o_lost, o_VX);
        end
        strobe(1'b1, 16'd100);
        model_frame(1'b1, 100);
        n_vec++;
        if (obs !== exp_vec() || o_X !== 16'd100 || o_VX !== 16'd0 || o_tracking !== 1'b1) begin
            n_err++; $display("FAIL reacquire obs=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_saturation();
        do_reset();
        strobe(1'b1, 16'd0);
        model_frame(1'b1, 0);
        strobe(1'b1, 16'd200);
        model_frame(1'b1, 200);
        n_vec++;
        if (o2_VX !== 16'h7FFF || o2_X !== 16'd50) begin
            n_err++; $display("FAIL sat_pos vx=%h x=%0d exp vx=7fff x=50", o2_VX, o2_X);
        end
        n_vec++;
        if (obs !== exp_vec()) begin
            n_err++; $display("FAIL sat_pos_ref obs=%h exp=%h", obs, exp_vec());
        end
        do_reset();
        strobe(1'b1, 16'd200);
        model_frame(1'b1, 200);
        strobe(1'b1, 16'd0);
        model_frame(1'b1, 0);
        n_vec++;
        if (o2_VX !== 16'h8001 || o2_X !== 16'd150) begin
            n_err++; $display("FAIL sat_neg vx=%h x=%0d exp vx=8001 x=150", o2_VX, o2_X);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        strobe_pair(1'b1, 16'd300, 16'd310);
        model_frame(1'b1, 300);
        m_drop++;
        n_vec++;
        if (obs !== exp_vec()) begin
            n_err++; $display("FAIL b2b_first obs=%h exp=%h", obs, exp_vec());
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_vec++;
            if (o_update !== 1'b0) begin
                n_err++; $display("FAIL b2b_extra_update%0d upd=%b exp=0", i, o_update);
            end
        end
        // Second strobe two cycles after the first: still inside the busy window.
        pos_valid = 1'b1; found = 1'b1; pos_x = 16'd320;
        @(negedge clk);
        pos_valid = 1'b0;
        @(negedge clk);
        pos_valid = 1'b1; pos_x = 16'd330;
        @(negedge clk);
        pos_valid = 1'b0;
        model_frame(1'b1, 320);
        m_drop++;
        n_vec++;
        if (obs !== exp_vec()) begin
            n_err++; $display("FAIL gap2_first obs=%h exp=%h", obs, exp_vec());
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_vec++;
            if (o_update !== 1'b0) begin
                n_err++; $display("FAIL gap2_extra_update%0d upd=%b exp=0", i, o_update);
            end
        end
        pos_valid = 1'b1; found = 1'b1; pos_x = 16'd700;
        @(negedge clk);
        pos_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (obs !== 67'd0) begin
                n_err++; $display("FAIL cancel%0d obs=%h exp=%h", i, obs, 67'd0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int nx;
        bit f;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            f = ($urandom_range(0, 99) < ((i < 150) ? 85 : 35));
            if ($urandom_range(0, 7) == 0) nx = int'($urandom_range(0, 65535));
            else begin
                nx = m_last + int'($urandom_range(0, 500)) - 250;
                if (nx < 0) nx = 0;
                if (nx > 65535) nx = 65535;
            end
            if ($urandom_range(0, 9) == 0) begin
                strobe_pair(f, 16'(nx), 16'($urandom_range(0, 65535)));
                model_frame(f, nx);
                m_drop++;
            end else begin
                strobe(f, 16'(nx));
                model_frame(f, nx);
            end
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL rand%0d f=%b x=%0d obs=%h exp=%h", i, f, nx, obs, exp_vec());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; pos_valid = 1'b0; found = 1'b0; pos_x = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_track();
        test_gate();
        test_lost();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
